// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - timestamped commit-trace capture FIFO
//
// Samples the core's register-write and data-memory activity every clock.
// Each active cycle becomes one record, and the record is pushed into a
// first-word-fall-through FIFO. Records drain over a valid/ready stream.
//
// Ports:
//   clk, reset            core clock; synchronous active-high reset
//   enable                capture enable (buffered records still drain when low)
//   reg_write_sig/num/data register-file write observation
//   wr, rd, addr          data-memory strobes and word address
//   wr_data, rd_data      data-memory write / read data
//   out_valid/ready/data  head-of-FIFO record stream
//   drop_count            saturating count of events lost to a full FIFO
//   overflow              sticky flag, set on the first drop
//
// Record layout, MSB first:
//   {stamp, lost, reg_we, mem_wr, mem_rd, reg_num, reg_data, addr, mem_data}

module trace_capture #(
  parameter int DEPTH = 16,
  parameter int CYC_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  reg_write_sig,
  input  logic [4:0]            reg_num,
  input  logic [31:0]           reg_data,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [8:0]            addr,
  input  logic [31:0]           wr_data,
  input  logic [31:0]           rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [82+CYC_W-1:0]   out_data,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam int REC_W = 82 + CYC_W;
  localparam int AW    = $clog2(DEPTH);

  logic [CYC_W-1:0] cyc_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic             lost_pending_q;
  logic [15:0]      drop_count_q;
  logic             overflow_q;

  logic             event_d;
  logic             empty_d;
  logic             full_d;
  logic             pop_d;
  logic             push_d;
  logic             drop_d;
  logic [REC_W-1:0] rec_d;
  logic [31:0]      mem_data_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_d = (wr_ptr_q == rd_ptr_q);
  assign full_d  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign event_d = enable && (reg_write_sig || wr || rd);
  assign pop_d   = !empty_d && out_ready;
  // A same-cycle pop frees the slot the push needs, so full + pop still pushes.
  assign push_d  = event_d && (!full_d || pop_d);
  assign drop_d  = event_d && full_d && !pop_d;

  // Write data wins over read data for the illegal wr=rd=1 case.
  always_comb begin
    mem_data_d = 32'd0;
    if (wr) begin
      mem_data_d = wr_data;
    end else if (rd) begin
      mem_data_d = rd_data;
    end
  end

  assign rec_d = {cyc_q,
                  lost_pending_q,
                  reg_write_sig,
                  wr,
                  rd,
                  reg_write_sig ? reg_num  : 5'd0,
                  reg_write_sig ? reg_data : 32'd0,
                  (wr || rd)    ? addr     : 9'd0,
                  mem_data_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      lost_pending_q <= 1'b0;
      drop_count_q   <= 16'd0;
      overflow_q     <= 1'b0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // The lost marker rides on the next record that actually enters the FIFO.
      if (drop_d) begin
        lost_pending_q <= 1'b1;
      end else if (push_d) begin
        lost_pending_q <= 1'b0;
      end
      if (drop_d && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
      if (drop_d) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_d && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec_d;
    end
  end

  assign out_valid  = !empty_d;
  assign out_data   = empty_d ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - directed bench for trace_capture with queue model

module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int CYC_W = 16;
  localparam int REC_W = 82 + CYC_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic             reg_write_sig = 1'b0;
  logic [4:0]       reg_num = 5'd0;
  logic [31:0]      reg_data = 32'd0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [8:0]       addr = 9'd0;
  logic [31:0]      wr_data = 32'd0;
  logic [31:0]      rd_data = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [REC_W-1:0] out_data;
  logic [15:0]      drop_count;
  logic             overflow;

  trace_capture #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of records plus counters.
  logic [REC_W-1:0] mq[$];
  logic [CYC_W-1:0] m_cyc = '0;
  logic             m_lost = 1'b0;
  int               m_drops = 0;
  logic             m_ovf = 1'b0;
  bit               started = 0;

  function automatic logic [REC_W-1:0] make_rec();
    logic [31:0] md;
    md = wr ? wr_data : (rd ? rd_data : 32'd0);
    return {m_cyc, m_lost, reg_write_sig, wr, rd,
            reg_write_sig ? reg_num : 5'd0,
            reg_write_sig ? reg_data : 32'd0,
            (wr | rd) ? addr : 9'd0, md};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_cyc = '0; m_lost = 1'b0; m_drops = 0; m_ovf = 1'b0;
      started = 1;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (enable && (reg_write_sig || wr || rd)) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(make_rec());
          m_lost = 1'b0;
        end else begin
          if (m_drops < 65535) m_drops++;
          m_ovf = 1'b1;
          m_lost = 1'b1;
        end
      end
      m_cyc = m_cyc + 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("model_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("model_data", out_data, mq[0]);
      chk("model_drops", drop_count, m_drops);
      chk("model_ovf", overflow, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_sig = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wr_ev(input int i);
    reg_write_sig = 1'b0; rd = 1'b0; wr = 1'b1;
    addr = 9'(i); wr_data = 32'h1000 + 32'(i);
  endtask

  int               prev_stamp;
  int               n_drained;
  logic [REC_W-1:0] exp_rec;

  initial begin
    // reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_drops", drop_count, 16'd0);
    chk("rst_ovf", overflow, 1'b0);

    // single register write at counter 3
    repeat (3) tick();
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hFFFFFFF6;
    tick();
    idle();
    exp_rec = {16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hFFFFFFF6, 9'd0, 32'd0};
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, exp_rec);
    chk("t1_model", mq[0], exp_rec);
    out_ready = 1'b1;
    tick();
    chk("t1_drained", out_valid, 1'b0);

    // combined register write + memory read
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'd42;
    rd = 1'b1; addr = 9'h010; rd_data = 32'h1234; wr_data = 32'hDEAD;
    out_ready = 1'b0;
    tick();
    idle();
    chk("t2_flags", out_data[81:78], 4'b0101);
    chk("t2_regnum", out_data[77:73], 5'd7);
    chk("t2_regdata", out_data[72:41], 32'd42);
    chk("t2_addr", out_data[40:32], 9'h010);
    chk("t2_memdata", out_data[31:0], 32'h1234);
    // illegal wr=rd=1: both flags, write data carried
    wr = 1'b1; rd = 1'b1; addr = 9'h1FF; wr_data = 32'hCAFE0001; rd_data = 32'h5555;
    out_ready = 1'b1;
    tick();
    idle();
    chk("t2b_flags", out_data[81:78], 4'b0011);
    chk("t2b_memdata", out_data[31:0], 32'hCAFE0001);
    chk("t2b_addr", out_data[40:32], 9'h1FF);
    tick();

    // back-pressure and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_ev(i);
      tick();
    end
    idle();
    chk("t3_drops", drop_count, 16'd4);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_buffered", mq.size(), 16);
    out_ready = 1'b1;
    prev_stamp = -1;
    n_drained = 0;
    while (out_valid && n_drained < 40) begin
      chk("t3_stamp_incr", (int'(out_data[97:82]) > prev_stamp), 1'b1);
      prev_stamp = int'(out_data[97:82]);
      n_drained++;
      tick();
    end
    chk("t3_drained", n_drained, 16);
    wr_ev(50);
    tick();
    chk("t3_lost1", {out_valid, out_data[81]}, 2'b11);
    wr_ev(51);
    tick();
    idle();
    chk("t3_lost0", {out_valid, out_data[81]}, 2'b10);
    tick();

    // full with simultaneous pop and push
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_ev(100 + i);
      tick();
    end
    chk("t4_full_drops", drop_count, 16'd4);
    out_ready = 1'b1;
    wr_ev(200);
    tick();
    idle();
    chk("t4_nodrop", drop_count, 16'd4);
    chk("t4_occupancy", mq.size(), 16);
    chk("t4_head_addr", out_data[40:32], 9'd101);
    repeat (20) tick();
    chk("t4_empty", out_valid, 1'b0);

    // enable=0: no records, no drops even when full
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_ev(i);
      tick();
    end
    enable = 1'b0;
    repeat (3) begin wr_ev(77); tick(); end
    chk("t5_nodrop", drop_count, 16'd4);
    out_ready = 1'b1;
    repeat (20) tick();
    repeat (3) begin wr_ev(78); tick(); end
    chk("t5_norecord", out_valid, 1'b0);
    idle();
    enable = 1'b1;

    // reset mid-drain
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_ev(i);
      tick();
    end
    idle();
    chk("t6_pre_valid", out_valid, 1'b1);
    chk("t6_pre_ovf", overflow, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_drops", drop_count, 16'd0);
    chk("t6_ovf", overflow, 1'b0);
    wr_ev(3);
    tick();
    idle();
    chk("t6_stamp", {out_valid, out_data[97:82]}, {1'b1, 16'd0});
    out_ready = 1'b1;
    tick();

    // counter wrap: event at absolute cycle 65538 after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (65538) tick();
    wr_ev(9);
    tick();
    idle();
    chk("t7_wrap_stamp", {out_valid, out_data[97:82]}, {1'b1, 16'd2});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Hardware commit-trace buffer that sits directly downstream of the `riscv` core's observation ports. Each clock, it samples the register-write and data-memory activity signals. Every active cycle is packed into one timestamped record and pushed into a first-word-fall-through FIFO. Records drain over a valid/ready stream to a UART or debug host, replacing printf-style monitoring on silicon and FPGA builds.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, ≥ 2.
- `CYC_W`, 16: cycle-stamp width; record width `REC_W = 82 + CYC_W`.

Ports:
- `clk`  in  1: core clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: capture enable; when 0, no events are recorded or dropped.
- `reg_write_sig`  in  1: core register-file write strobe.
- `reg_num`  in  5: written register index.
- `reg_data`  in  32: written register value.
- `wr`  in  1: data-memory write strobe.
- `rd`  in  1: data-memory read strobe.
- `addr`  in  9: data-memory word address.
- `wr_data`  in  32: memory write data.
- `rd_data`  in  32: memory read data.
- `out_valid`  out  1: head record available.
- `out_ready`  in  1: consumer accepts the head record.
- `out_data`  out  REC_W: head record.
- `drop_count`  out  16: saturating count of lost events.
- `overflow`  out  1: sticky; set on the first drop.

## Operation

- **Event**: a sampling edge with `enable=1` and at least one of `reg_write_sig`, `wr`, `rd` high.
- **Record layout**, MSB first:
  - `[81+CYC_W:82]` cycle stamp
  - `[81]` lost
  - `[80]` reg_we
  - `[79]` mem_wr
  - `[78]` mem_rd
  - `[77:73]` reg_num
  - `[72:41]` reg_data
  - `[40:32]` addr
  - `[31:0]` mem_data
- **Field rules**:
  - `reg_num` and `reg_data` are 0 when `reg_write_sig=0`.
  - `addr` is 0 when `wr=rd=0`.
  - `mem_data` is `wr_data` if `wr`, else `rd_data` if `rd`, else 0.
  - `wr=rd=1` is illegal on the core. The record sets both flags and carries `wr_data`.
- **Cycle counter**: CYC_W-bit, 0 in the cycle after reset. Increments every edge regardless of `enable` and wraps to 0. The stamp is the counter value at the sampling edge.
- **FIFO**: `DEPTH` entries, pointers of log2(DEPTH)+1 bits.
  - Push on an event when not full, or when full with a pop in the same cycle.
  - Pop when `out_valid && out_ready`.
- **Drop**: an event that finds the FIFO full with no same-cycle pop is discarded.
  - `drop_count` increments and saturates at 0xFFFF.
  - `overflow` is set and held until reset.
  - An internal `lost_pending` flag is set.
- **Lost flag**: the next accepted record carries `lost=1`, then `lost_pending` clears.
- **Enable**: deasserting `enable` does not flush; buffered records still drain.

## Timing

- **Reset values**: `out_valid=0`, `out_data=0`, `drop_count=0`, `overflow=0`, counter 0, FIFO empty, `lost_pending=0`.
- **Latency**: event sampled at edge N; record is visible with `out_valid=1` after edge N (same cycle N+1). No combinational path from event inputs to `out_*`.
- **Output stability**: `out_data` stays stable while `out_valid=1 && out_ready=0`.
- **`out_ready`**: may be asserted while `out_valid=0`, with no effect.
- **Throughput**: one push and one pop per cycle sustained.
- **Full with pop and event, same edge**: both occur; occupancy unchanged; no drop.
- **Empty with event**: the record appears the next cycle. There is no same-cycle bypass.
- **Reset mid-stream**: all contents are discarded at the reset edge. `out_valid` is 0 in the following cycle even if `out_ready` was low.

## Test plan

1. **Single register write**: reset, then `reg_write_sig=1`, `reg_num=5`, `reg_data=0xFFFFFFF6` at counter 3 → one cycle later `out_valid=1`, stamp=3, reg_we=1, reg_num=5, reg_data=0xFFFFFFF6, mem fields 0.
2. **Combined event**: `reg_write_sig=1` (x7=42) together with `rd=1`, `addr=9'h010`, `rd_data=0x1234` → a single record with reg_we=1, mem_rd=1, mem_wr=0, mem_data=0x1234.
3. **Back-pressure and overflow**:
   - Hold `out_ready=0`, `DEPTH=16`; drive 20 consecutive write events.
   - Expect 16 buffered, `drop_count=4`, `overflow=1`.
   - Release `out_ready`: records drain in order with stamps strictly increasing.
   - The next new event carries lost=1; the one after carries lost=0.
4. **Full with simultaneous pop and push**: FIFO full, `out_ready=1`, event present → pop and push both happen; `drop_count` unchanged; order preserved.
5. **Enable and wrap**:
   - With `enable=0`, write events produce no records and no drops.
   - Run 65 540 cycles with `CYC_W=16`: the stamp of an event at absolute cycle 65 538 reads 2.
6. **Reset mid-drain**: 5 records buffered, `out_ready=0`, assert `reset` one cycle → `out_valid=0`, `drop_count=0`, `overflow=0`; the next event's stamp counts from 0 after reset.
